// File: rtl/tone_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// tone_sequencer_pkg
// Shared types and constants for the tone sequencer slice.
//   - state_e      : playback FSM encoding (IDLE=0, PLAY=1)
//   - DEF_*        : default parameter values for the sequencer and its interface
//   - cmd_width()  : command word width from the duration/period field widths
//   - cnt_width()  : width of a counter that must hold (2**field_w - 1) * scale
// -----------------------------------------------------------------------------
package tone_sequencer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam int DEF_PRESCALE = 1;
    localparam int DEF_DUR_UNIT = 512;
    localparam int DEF_PERIOD_W = 8;
    localparam int DEF_DUR_W    = 4;
    localparam int DEF_DEPTH    = 4;

    // Command word is {dur, period}.
    function automatic int cmd_width(input int dur_w, input int period_w);
        return dur_w + period_w;
    endfunction

    // Smallest width able to hold the largest field value times its scale,
    // so a counter loaded once per note never wraps.
    function automatic int cnt_width(input int field_w, input int scale);
        int max_val;
        max_val = ((32'sd1 <<< field_w) - 32'sd1) * scale;
        if (max_val < 32'sd2) begin
            return 1;
        end else begin
            return $clog2(max_val + 32'sd1);
        end
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// -----------------------------------------------------------------------------
// tone_sequencer_if
// Command handshake between a score/ROM walker (master) and the sequencer
// (slave).
//   cmd       : {dur, period} note command
//   cmd_valid : command present
//   cmd_ready : sequencer can accept (combinational in the slave)
// -----------------------------------------------------------------------------
interface tone_sequencer_if
    import tone_sequencer_pkg::*;
#(
    parameter int CMD_W = cmd_width(DEF_DUR_W, DEF_PERIOD_W)
);
    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic             cmd_ready;

    modport master (output cmd, output cmd_valid, input cmd_ready);
    modport slave  (input cmd, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/tone_sequencer_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tone_sequencer_cmd_fifo
// Synchronous command FIFO with synchronous clear.
//   clk        in   clock, rising edge
//   clr_i      in   synchronous clear (reset or flush), wins over push/pop
//   push_i     in   write din_i (ignored when full)
//   pop_i      in   advance read pointer (ignored when empty)
//   din_i      in   write data
//   dout_o     out  head-of-queue data (valid when !empty_o)
//   full_o     out  occupancy == DEPTH
//   empty_o    out  occupancy == 0
//   level_o    out  registered occupancy
//   level_nxt_o out occupancy after the coming edge
// -----------------------------------------------------------------------------
module tone_sequencer_cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [$clog2(DEPTH+1)-1:0] level_nxt_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1'b1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full_o      = (count_q == LVL_MAX);
    assign empty_o     = (count_q == '0);
    assign push_ok_s   = push_i & ~full_o & ~clr_i;
    assign pop_ok_s    = pop_i & ~empty_o & ~clr_i;
    assign dout_o      = mem_q[rd_ptr_q];
    assign level_o     = count_q;
    assign level_nxt_o = count_d;

    // Next pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + LVL_ONE;
                2'b01:   count_d = count_q - LVL_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Storage write; contents need no clear because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
// Queues {dur, period} note commands and plays them back-to-back as a square
// wave. period==0 is a rest, dur==0 retires the command without playing.
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   cmd_if       slave handshake: cmd, cmd_valid in; cmd_ready out (combinational)
//   flush_i      in   drop queued commands and abort the current note
//   busy_o       out  note playing or FIFO non-empty (registered)
//   q_o          out  square-wave output (registered)
//   note_done_o  out  one-cycle pulse per retired command (registered)
//   level_o      out  FIFO occupancy (registered)
// -----------------------------------------------------------------------------
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int DUR_UNIT = DEF_DUR_UNIT,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int DUR_W    = DEF_DUR_W,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    tone_sequencer_if.slave            cmd_if,
    input  logic                       flush_i,
    output logic                       busy_o,
    output logic                       q_o,
    output logic                       note_done_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int CMD_W      = cmd_width(DUR_W, PERIOD_W);
    localparam int DUR_MSB    = CMD_W - 1;
    localparam int PERIOD_MSB = PERIOD_W - 1;
    localparam int DCNT_W     = cnt_width(DUR_W, DUR_UNIT);
    localparam int HCNT_W     = cnt_width(PERIOD_W, PRESCALE);
    localparam int LVL_W      = $clog2(DEPTH + 1);

    localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1'b1);
    localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1'b1);

    // FIFO side
    logic [CMD_W-1:0]    fifo_dout_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [LVL_W-1:0]    fifo_lvl_nxt_s;
    logic                clr_s;
    logic                push_s;
    logic                pop_s;

    // Head-of-queue fields and the counts they load
    logic [DUR_W-1:0]    head_dur_s;
    logic [PERIOD_W-1:0] head_per_s;
    logic [DCNT_W-1:0]   dur_load_s;
    logic [HCNT_W-1:0]   half_load_s;

    // Playback state
    state_e              state_q, state_d;
    logic [DCNT_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [HCNT_W-1:0]   half_cnt_q, half_cnt_d;
    logic [HCNT_W-1:0]   half_rl_q, half_rl_d;
    logic                q_q, q_d;
    logic                note_done_q, note_done_d;
    logic                busy_q, busy_d;

    assign clr_s            = rst | flush_i;
    assign cmd_if.cmd_ready = ~fifo_full_s & ~flush_i & ~rst;
    assign push_s           = cmd_if.cmd_valid & cmd_if.cmd_ready;
    // Only an idle sequencer consumes the head; this also covers the gap cycle.
    assign pop_s            = (state_q == ST_IDLE) & ~fifo_empty_s & ~clr_s;

    assign head_dur_s  = fifo_dout_s[DUR_MSB:PERIOD_W];
    assign head_per_s  = fifo_dout_s[PERIOD_MSB:0];
    assign dur_load_s  = DCNT_W'(head_dur_s) * DCNT_W'(DUR_UNIT);
    assign half_load_s = HCNT_W'(head_per_s) * HCNT_W'(PRESCALE);

    tone_sequencer_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .clr_i       (clr_s),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .din_i       (cmd_if.cmd),
        .dout_o      (fifo_dout_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .level_o     (level_o),
        .level_nxt_o (fifo_lvl_nxt_s)
    );

    // Playback FSM: note start/end, duration countdown and half-period toggling.
    always_comb begin
        state_d     = state_q;
        dur_cnt_d   = dur_cnt_q;
        half_cnt_d  = half_cnt_q;
        half_rl_d   = half_rl_q;
        q_d         = q_q;
        note_done_d = 1'b0;
        if (clr_s) begin
            // Abort without retiring: no note_done for a flushed note.
            state_d    = ST_IDLE;
            dur_cnt_d  = '0;
            half_cnt_d = '0;
            half_rl_d  = '0;
            q_d        = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    q_d = 1'b0;
                    if (pop_s) begin
                        if (head_dur_s != '0) begin
                            state_d    = ST_PLAY;
                            dur_cnt_d  = dur_load_s;
                            half_cnt_d = half_load_s;
                            half_rl_d  = half_load_s;
                            // A tone starts high; a rest (period 0) stays low.
                            q_d        = (head_per_s != '0);
                        end else begin
                            note_done_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (dur_cnt_q == DCNT_ONE) begin
                        // Last PLAY cycle: next cycle is the one-cycle low gap.
                        state_d     = ST_IDLE;
                        dur_cnt_d   = '0;
                        half_cnt_d  = '0;
                        q_d         = 1'b0;
                        note_done_d = 1'b1;
                    end else begin
                        dur_cnt_d = dur_cnt_q - DCNT_ONE;
                        if (half_rl_q == '0) begin
                            q_d = 1'b0;
                        end else if (half_cnt_q == HCNT_ONE) begin
                            half_cnt_d = half_rl_q;
                            q_d        = ~q_q;
                        end else begin
                            half_cnt_d = half_cnt_q - HCNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    q_d     = 1'b0;
                end
            endcase
        end
        // busy is registered, so it is built from the values the next cycle will hold.
        busy_d = (state_d == ST_PLAY) | (fifo_lvl_nxt_s != '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dur_cnt_q   <= '0;
            half_cnt_q  <= '0;
            half_rl_q   <= '0;
            q_q         <= 1'b0;
            note_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dur_cnt_q   <= dur_cnt_d;
            half_cnt_q  <= half_cnt_d;
            half_rl_q   <= half_rl_d;
            q_q         <= q_d;
            note_done_q <= note_done_d;
            busy_q      <= busy_d;
        end
    end

    assign q_o         = q_q;
    assign note_done_o = note_done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tone_sequencer
// Directed self-checking bench for tone_sequencer with PRESCALE=1,
// DUR_UNIT=16, DEPTH=4. Inputs change and outputs are sampled just after the
// rising edge; traces are compared against a small note-timing model.
// -----------------------------------------------------------------------------
module tb_tone_sequencer;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       busy;
    logic       q;
    logic       note_done;
    logic [2:0] level;

    int checks;
    int failures;

    tone_sequencer_if #(.CMD_W(12)) cmd_if ();

    tone_sequencer #(
        .PRESCALE (1),
        .DUR_UNIT (16),
        .PERIOD_W (8),
        .DUR_W    (4),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_if      (cmd_if),
        .flush_i     (flush),
        .busy_o      (busy),
        .q_o         (q),
        .note_done_o (note_done),
        .level_o     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus queue and recorded trace
    logic [11:0] pend[$];
    logic [11:0] exp_notes[$];
    logic        tr_q    [256];
    logic        tr_nd   [256];
    logic        tr_busy [256];
    logic        tr_rdy  [256];
    logic [2:0]  tr_lvl  [256];
    logic        exp_q   [256];
    logic        exp_nd  [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Offer queued commands with valid held until accepted; record outputs per cycle.
    task automatic run_trace(input int n);
        logic acc;
        for (int k = 0; k < n; k++) begin
            if (pend.size() > 0) begin
                cmd_if.cmd       = pend[0];
                cmd_if.cmd_valid = 1'b1;
            end else begin
                cmd_if.cmd_valid = 1'b0;
            end
            #1;
            tr_q[k]    = q;
            tr_nd[k]   = note_done;
            tr_busy[k] = busy;
            tr_rdy[k]  = cmd_if.cmd_ready;
            tr_lvl[k]  = level;
            acc        = cmd_if.cmd_valid & cmd_if.cmd_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(pend.pop_front());
            end
        end
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Expected q / note_done: each note plays dur*16 cycles from 'start',
    // q high first and toggling every period cycles, then one gap cycle
    // carrying note_done, after which the next note starts.
    task automatic build_expect(input int start);
        int t;
        int d;
        int p;
        for (int k = 0; k < 256; k++) begin
            exp_q[k]  = 1'b0;
            exp_nd[k] = 1'b0;
        end
        t = start;
        foreach (exp_notes[j]) begin
            d = int'(exp_notes[j][11:8]) * 16;
            p = int'(exp_notes[j][7:0]);
            for (int i = 0; i < d; i++) begin
                if (p != 0) begin
                    exp_q[t + i] = (((i / p) % 2) == 0);
                end
            end
            t = t + d;
            exp_nd[t] = 1'b1;
            t = t + 1;
        end
    endtask

    task automatic compare_trace(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s.q@%0d", tag, k), 32'(tr_q[k]), 32'(exp_q[k]));
            check($sformatf("%s.note_done@%0d", tag, k), 32'(tr_nd[k]), 32'(exp_nd[k]));
        end
    endtask

    // Queue three notes, abort mid first note with flush or rst while
    // offering a command, then confirm everything is dropped.
    task automatic abort_case(input bit use_rst, input string tag);
        int nd_cnt;
        int q_cnt;
        pend = {12'h402, 12'h203, 12'h305};
        run_trace(10);
        check({tag, ".q_playing"}, 32'(tr_q[2]), 32'd1);
        check({tag, ".level_before"}, 32'(tr_lvl[9]), 32'd2);
        cmd_if.cmd       = 12'h111;
        cmd_if.cmd_valid = 1'b1;
        if (use_rst) begin
            rst = 1'b1;
        end else begin
            flush = 1'b1;
        end
        #1;
        check({tag, ".ready_blocked"}, 32'(cmd_if.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".q_after"}, 32'(q), 32'd0);
        check({tag, ".level_after"}, 32'(level), 32'd0);
        check({tag, ".busy_after"}, 32'(busy), 32'd0);
        check({tag, ".note_done_after"}, 32'(note_done), 32'd0);
        rst              = 1'b0;
        flush            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        #1;
        check({tag, ".ready_restored"}, 32'(cmd_if.cmd_ready), 32'd1);
        nd_cnt = 0;
        q_cnt  = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            nd_cnt += int'(note_done);
            q_cnt  += int'(q);
        end
        check({tag, ".note_done_count"}, 32'(nd_cnt), 32'd0);
        check({tag, ".q_high_count"}, 32'(q_cnt), 32'd0);
        check({tag, ".level_settled"}, 32'(level), 32'd0);
        check({tag, ".busy_settled"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        flush            = 1'b0;
        cmd_if.cmd       = 12'h000;
        cmd_if.cmd_valid = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst.q", 32'(q), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.level", 32'(level), 32'd0);
        check("rst.note_done", 32'(note_done), 32'd0);
        check("rst.ready_in_rst", 32'(cmd_if.cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.ready_after", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single tone: dur 4 (64 cycles), half-period 2
        pend      = {12'h402};
        exp_notes = {12'h402};
        run_trace(69);
        build_expect(2);
        compare_trace("tone", 69);
        check("tone.busy_before", 32'(tr_busy[0]), 32'd0);
        check("tone.busy_queued", 32'(tr_busy[1]), 32'd1);
        check("tone.level_queued", 32'(tr_lvl[1]), 32'd1);
        check("tone.busy_last_play", 32'(tr_busy[65]), 32'd1);
        check("tone.busy_gap", 32'(tr_busy[66]), 32'd0);
        check("tone.busy_idle", 32'(tr_busy[68]), 32'd0);

        // Back-to-back tone, rest, tone
        pend      = {12'h203, 12'h100, 12'h305};
        exp_notes = {12'h203, 12'h100, 12'h305};
        run_trace(103);
        build_expect(2);
        compare_trace("b2b", 103);
        check("b2b.busy_gap1", 32'(tr_busy[34]), 32'd1);
        check("b2b.busy_gap2", 32'(tr_busy[51]), 32'd1);
        check("b2b.busy_end", 32'(tr_busy[100]), 32'd0);

        // Full FIFO: first note plays while five more are offered
        pend      = {12'h105, 12'h207, 12'h109, 12'h30B, 12'h10D, 12'h20F};
        exp_notes = {12'h105, 12'h207, 12'h109, 12'h30B, 12'h10D, 12'h20F};
        run_trace(170);
        build_expect(2);
        compare_trace("full", 170);
        check("full.level_max", 32'(tr_lvl[5]), 32'd4);
        check("full.ready_full", 32'(tr_rdy[5]), 32'd0);
        check("full.ready_gap", 32'(tr_rdy[18]), 32'd0);
        check("full.level_gap", 32'(tr_lvl[18]), 32'd4);
        check("full.ready_after_pop", 32'(tr_rdy[19]), 32'd1);
        check("full.level_after_pop", 32'(tr_lvl[19]), 32'd3);
        check("full.level_refill", 32'(tr_lvl[20]), 32'd4);
        check("full.all_accepted", 32'(pend.size()), 32'd0);
        check("full.busy_end", 32'(tr_busy[168]), 32'd0);

        // Zero-duration command
        pend      = {12'h040};
        exp_notes = {12'h040};
        run_trace(6);
        build_expect(2);
        compare_trace("zero", 6);
        check("zero.busy_queued", 32'(tr_busy[1]), 32'd1);
        check("zero.level_popped", 32'(tr_lvl[2]), 32'd0);
        check("zero.busy_done", 32'(tr_busy[2]), 32'd0);

        // Flush and reset mid-note
        abort_case(1'b0, "flush");
        abort_case(1'b1, "rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
